traffic_intersection_ctrl: RTL and testbench
============================================

Name: traffic_intersection_ctrl

Overview:
- Parametrised, demand-responsive successor to the fixed-cycle three-light controller.
- Drives NUM_DIRS conflicting approaches, each with its own red/yellow/green triple.
- Sequences green -> yellow -> all-red phases with per-phase cycle counts.
- Serves approaches round-robin, skips approaches with no vehicle demand, and holds green while no other approach is requesting.

Parameters:
- NUM_DIRS, 4, number of approaches; legal range 2..8.
- DIR_W, 2, width of the direction index; must be >= clog2(NUM_DIRS).
- GREEN_CYCLES, 20, minimum green duration in clk cycles; must be >= 1.
- YELLOW_CYCLES, 4, yellow duration in clk cycles; must be >= 1.
- ALLRED_CYCLES, 2, all-red clearance duration in clk cycles; must be >= 1.
- CNT_W, 8, phase timer width; must hold max(all *_CYCLES) - 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- sensor  input  NUM_DIRS  vehicle-present request per approach; level, sampled every cycle.
- lights  output  3*NUM_DIRS  approach i occupies bits [3i+2:3i] = {red, yellow, green}; exactly one bit set per approach.
- active_dir  output  DIR_W  approach currently owning (or last owning) the green/yellow phase.
- phase  output  2  00 = ALL_RED, 01 = GREEN, 10 = YELLOW; 11 never driven.

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on rst, sampled at the clk rising edge.
- Reset values:
  - state = ALL_RED, phase = 00.
  - active_dir = NUM_DIRS-1.
  - timer = ALLRED_CYCLES-1.
  - every lights triple = 100 (red).
- Reset asserted mid-phase overrides everything on that edge. No yellow is forced first.
- Timer: loaded with (N-1) on phase entry and decremented each cycle. A phase therefore lasts exactly N cycles; "expiry" means timer == 0.
- Outputs are registered and change on the same edge as the state register. There is no combinational path from sensor to lights.
- ALL_RED (all triples 100):
  - On expiry, choose next = first approach with sensor high, scanning active_dir+1, active_dir+2, ... with wrap modulo NUM_DIRS.
  - active_dir itself is the last candidate scanned.
  - If no sensor is high, next = (active_dir+1) mod NUM_DIRS (fixed-time fallback).
  - Then load active_dir = next and enter GREEN.
- GREEN:
  - Active approach triple = 001; all others 100.
  - On expiry, if any other approach's sensor is high -> YELLOW.
  - Else if sensor[active_dir] is high -> stay GREEN and reload the timer with GREEN_CYCLES-1 (extension; no limit).
  - Else -> YELLOW.
- YELLOW:
  - Active approach triple = 010; others 100.
  - On expiry -> ALL_RED.
- Wrap-around: the direction index wraps from NUM_DIRS-1 to 0. Index values >= NUM_DIRS are never produced.
- Sensor changes mid-phase have no effect until that phase's expiry cycle.
- Safety invariant: at most one approach is non-red in any cycle.

Optional Feature:
- Macro: TRAFFIC_PED_WALK_EN.
- With the macro defined:
  - Extra input ped_req (1 bit), extra output walk (1 bit, reset 0), extra parameter WALK_CYCLES (default 10).
  - ped_req pulses latch into a sticky ped_pending flag; multiple pulses collapse to one.
  - At ALL_RED expiry with ped_pending set, enter WALK instead of GREEN. phase = 11; all triples 100; walk = 1 for WALK_CYCLES cycles.
  - ped_pending clears on WALK entry.
  - After WALK, go to ALL_RED again (ALLRED_CYCLES), then normal selection with active_dir unchanged.
  - ped_pending also forces GREEN expiry to YELLOW, exactly as an other-approach request would.
- Without the macro: no ped ports, phase 11 unused, behaviour exactly as above.

Test Plan:
- Reset, all sensors 0, default parameters:
  - ALL_RED for 2 cycles, then dir0 GREEN for 20, YELLOW for 4, ALL_RED for 2.
  - Then dir1 GREEN; dirs cycle 0, 1, 2, 3, 0.
  - Full cycle = 4 x 26 cycles.
- Only sensor[2] held high from reset: dir2 GREEN and stays green indefinitely (timer reloads every 20 cycles), with lights[8:6] = 001 throughout.
- dir2 green with sensor[2] high, then sensor[0] and sensor[3] rise at cycle 5 of green:
  - Yellow begins at cycle 20.
  - After all-red, dir3 is served (round-robin after 2), not dir0.
- Reset asserted during YELLOW on dir1: on the next edge all triples are 100, phase = 00, active_dir = 3, and the timer restarts at 1.
- Every-cycle assertion across a random-sensor run of 10k cycles: no two approaches non-red simultaneously, and each triple is one-hot.
- With TRAFFIC_PED_WALK_EN, ped_req pulsed during dir0 green:
  - Green ends at its expiry, then yellow 4, all-red 2, walk 10, all-red 2.
  - Then dir1 selects normally; walk is high for exactly 10 cycles.

Source files
------------

// File: rtl/traffic_intersection_ctrl.sv
// Demand-responsive round-robin signal controller for NUM_DIRS conflicting approaches.
// Optional pedestrian walk phase is compiled in when TRAFFIC_PED_WALK_EN is defined.
module traffic_intersection_ctrl #(
  parameter int NUM_DIRS      = 4,
  parameter int DIR_W         = 2,
  parameter int GREEN_CYCLES  = 20,
  parameter int YELLOW_CYCLES = 4,
  parameter int ALLRED_CYCLES = 2,
  parameter int CNT_W         = 8
`ifdef TRAFFIC_PED_WALK_EN
  , parameter int WALK_CYCLES = 10
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_DIRS-1:0]   sensor,
`ifdef TRAFFIC_PED_WALK_EN
  input  logic                  ped_req,
  output logic                  walk,
`endif
  output logic [3*NUM_DIRS-1:0] lights,
  output logic [DIR_W-1:0]      active_dir,
  output logic [1:0]            phase
);

  typedef enum logic [1:0] {
    S_ALL_RED = 2'b00,
    S_GREEN   = 2'b01,
    S_YELLOW  = 2'b10,
    S_WALK    = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] C_GREEN_LD  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_YELLOW_LD = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_ALLRED_LD = CNT_W'(ALLRED_CYCLES - 1);
`ifdef TRAFFIC_PED_WALK_EN
  localparam logic [CNT_W-1:0] C_WALK_LD   = CNT_W'(WALK_CYCLES - 1);
`endif
  localparam logic [3*NUM_DIRS-1:0] C_ALL_RED_LIGHTS = {NUM_DIRS{3'b100}};

  state_t                r_state;
  logic [DIR_W-1:0]      r_dir;
  logic [CNT_W-1:0]      r_timer;
  logic [3*NUM_DIRS-1:0] r_lights;
  logic                  r_ped_pending;
  logic                  r_walk;

  state_t                w_state_nxt;
  logic [DIR_W-1:0]      w_dir_nxt;
  logic [CNT_W-1:0]      w_timer_nxt;
  logic [3*NUM_DIRS-1:0] w_lights_nxt;
  logic                  w_expired;
  logic [NUM_DIRS-1:0]   w_own_mask;
  logic                  w_other_req;
  logic                  w_own_req;
  logic                  w_ped_clr;
  logic                  w_ped_req;

  // First requesting approach after cur (cur itself last); cur+1 when nobody asks.
  function automatic logic [DIR_W-1:0] f_pick_next(input logic [DIR_W-1:0]    cur,
                                                   input logic [NUM_DIRS-1:0] req);
    logic [DIR_W-1:0] pick;
    logic             found;
    int               idx;
    idx = int'(cur) + 1;
    if (idx >= NUM_DIRS) idx = idx - NUM_DIRS;
    pick  = DIR_W'(idx);
    found = 1'b0;
    for (int k = 1; k <= NUM_DIRS; k++) begin
      idx = int'(cur) + k;
      if (idx >= NUM_DIRS) idx = idx - NUM_DIRS;
      if (!found && req[idx[DIR_W-1:0]]) begin
        pick  = DIR_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

`ifdef TRAFFIC_PED_WALK_EN
  assign w_ped_req = r_ped_pending;
`else
  assign w_ped_req = 1'b0;
`endif

  assign w_expired   = (r_timer == CNT_W'(0));
  assign w_own_mask  = {{(NUM_DIRS-1){1'b0}}, 1'b1} << r_dir;
  assign w_other_req = |(sensor & ~w_own_mask);
  assign w_own_req   = |(sensor & w_own_mask);

  // Next-state, next-direction and phase-timer selection.
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_timer_nxt = r_timer;
    w_ped_clr   = 1'b0;
    case (r_state)
      S_ALL_RED: begin
        if (!w_expired) begin
          w_timer_nxt = r_timer - CNT_W'(1);
        end else if (w_ped_req) begin
`ifdef TRAFFIC_PED_WALK_EN
          w_state_nxt = S_WALK;
          w_timer_nxt = C_WALK_LD;
          w_ped_clr   = 1'b1;
`endif
        end else begin
          w_state_nxt = S_GREEN;
          w_dir_nxt   = f_pick_next(r_dir, sensor);
          w_timer_nxt = C_GREEN_LD;
        end
      end
      S_GREEN: begin
        if (!w_expired) begin
          w_timer_nxt = r_timer - CNT_W'(1);
        end else if (w_other_req || w_ped_req) begin
          w_state_nxt = S_YELLOW;
          w_timer_nxt = C_YELLOW_LD;
        end else if (w_own_req) begin
          w_timer_nxt = C_GREEN_LD;
        end else begin
          w_state_nxt = S_YELLOW;
          w_timer_nxt = C_YELLOW_LD;
        end
      end
      S_YELLOW: begin
        if (!w_expired) begin
          w_timer_nxt = r_timer - CNT_W'(1);
        end else begin
          w_state_nxt = S_ALL_RED;
          w_timer_nxt = C_ALLRED_LD;
        end
      end
`ifdef TRAFFIC_PED_WALK_EN
      S_WALK: begin
        if (!w_expired) begin
          w_timer_nxt = r_timer - CNT_W'(1);
        end else begin
          w_state_nxt = S_ALL_RED;
          w_timer_nxt = C_ALLRED_LD;
        end
      end
`endif
      default: begin
        w_state_nxt = S_ALL_RED;
        w_timer_nxt = C_ALLRED_LD;
      end
    endcase
  end

  // Lights decoded from the next state so they register alongside it.
  always_comb begin
    w_lights_nxt = C_ALL_RED_LIGHTS;
    for (int i = 0; i < NUM_DIRS; i++) begin
      if (w_dir_nxt == DIR_W'(i) && w_state_nxt == S_GREEN) begin
        w_lights_nxt[3*i +: 3] = 3'b001;
      end else if (w_dir_nxt == DIR_W'(i) && w_state_nxt == S_YELLOW) begin
        w_lights_nxt[3*i +: 3] = 3'b010;
      end else begin
        w_lights_nxt[3*i +: 3] = 3'b100;
      end
    end
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_ALL_RED;
      r_dir         <= DIR_W'(NUM_DIRS - 1);
      r_timer       <= C_ALLRED_LD;
      r_lights      <= C_ALL_RED_LIGHTS;
      r_ped_pending <= 1'b0;
      r_walk        <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dir    <= w_dir_nxt;
      r_timer  <= w_timer_nxt;
      r_lights <= w_lights_nxt;
      r_walk   <= (w_state_nxt == S_WALK);
`ifdef TRAFFIC_PED_WALK_EN
      r_ped_pending <= w_ped_clr ? 1'b0 : (r_ped_pending | ped_req);
`else
      r_ped_pending <= 1'b0;
`endif
    end
  end

  assign lights     = r_lights;
  assign active_dir = r_dir;
  assign phase      = r_state;
`ifdef TRAFFIC_PED_WALK_EN
  assign walk       = r_walk;
`endif

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Self-checking bench for traffic_intersection_ctrl: phase/countdown model plus directed literal checks.
module tb_traffic_intersection_ctrl;
  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [ND-1:0] sensor = 4'b0000;
  logic          ped_req = 1'b0;
  logic          walk;
  logic [3*ND-1:0] lights;
  logic [1:0]    active_dir;
  logic [1:0]    phase;

  int checks = 0;
  int errors = 0;

  traffic_intersection_ctrl dut (
    .clk(clk),
    .rst(rst),
    .sensor(sensor),
`ifdef TRAFFIC_PED_WALK_EN
    .ped_req(ped_req),
    .walk(walk),
`endif
    .lights(lights),
    .active_dir(active_dir),
    .phase(phase)
  );
`ifndef TRAFFIC_PED_WALK_EN
  assign walk = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model: phase kind (0 all-red, 1 green, 2 yellow, 3 walk), cycles left in it, owner.
  int  m_ph = 0, m_left = 2, m_dir = ND - 1;
  bit  m_pend = 1'b0, m_valid = 1'b0;

  always @(posedge clk) begin
    bit old_pend, other, found;
    int j;
    if (rst) begin
      m_ph = 0; m_left = 2; m_dir = ND - 1; m_pend = 1'b0; m_valid = 1'b1;
    end else begin
      old_pend = m_pend;
`ifdef TRAFFIC_PED_WALK_EN
      if (ped_req) m_pend = 1'b1;
`endif
      if (m_left > 1) begin
        m_left = m_left - 1;
      end else begin
        case (m_ph)
          0: if (old_pend) begin
               m_ph = 3; m_left = 10; m_pend = 1'b0;
             end else begin
               found = 1'b0;
               for (int k = 1; k <= ND; k++) begin
                 j = (m_dir + k) % ND;
                 if (!found && sensor[j]) begin found = 1'b1; m_dir = j; end
               end
               if (!found) m_dir = (m_dir + 1) % ND;
               m_ph = 1; m_left = 20;
             end
          1: begin
               other = old_pend;
               for (int k = 0; k < ND; k++) if (k != m_dir && sensor[k]) other = 1'b1;
               if (!other && sensor[m_dir]) m_left = 20;
               else begin m_ph = 2; m_left = 4; end
             end
          default: begin m_ph = 0; m_left = 2; end
        endcase
      end
    end
  end

  // Every-cycle comparison of the DUT against the model and the safety invariant.
  always @(negedge clk) begin
    int nonred, exp_l;
    if (m_valid) begin
      exp_l = 0;
      nonred = 0;
      for (int i = 0; i < ND; i++) begin
        if (m_ph == 1 && i == m_dir)      exp_l |= 1 << (3 * i);
        else if (m_ph == 2 && i == m_dir) exp_l |= 2 << (3 * i);
        else                              exp_l |= 4 << (3 * i);
        if (lights[3*i +: 3] != 3'b100) nonred++;
        chk("triple_onehot", int'($onehot(lights[3*i +: 3])), 1);
      end
      chk("at_most_one_nonred", int'(nonred <= 1), 1);
      chk("model_lights", int'(lights), exp_l);
      chk("model_phase", int'(phase), m_ph);
      chk("model_dir", int'(active_dir), m_dir);
`ifdef TRAFFIC_PED_WALK_EN
      chk("model_walk", int'(walk), int'(m_ph == 3));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pd(input string name, input int ph, input int dir);
    chk({name, "_phase"}, int'(phase), ph);
    chk({name, "_dir"}, int'(active_dir), dir);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    chk("reset_lights", int'(lights), 12'h924);
    expect_pd("reset", 0, 3);
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    // Fixed-time fallback with no demand: 0,1,2,3,0 at 26 cycles each.
    sensor = 4'b0000;
    do_reset();
    step(1);  expect_pd("idle_allred2", 0, 3);
    step(1);  expect_pd("idle_g0", 1, 0);
    chk("idle_g0_lights", int'(lights), 12'h921);
    step(19); expect_pd("idle_g0_last", 1, 0);
    step(1);  expect_pd("idle_y0", 2, 0);
    chk("idle_y0_lights", int'(lights), 12'h922);
    step(3);  expect_pd("idle_y0_last", 2, 0);
    step(1);  expect_pd("idle_ar0", 0, 0);
    step(1);  expect_pd("idle_ar0_last", 0, 0);
    step(1);  expect_pd("idle_g1", 1, 1);
    step(26); expect_pd("idle_g2", 1, 2);
    step(26); expect_pd("idle_g3", 1, 3);
    step(26); expect_pd("idle_g0_again", 1, 0);

    // Sole demand on dir2 holds green indefinitely.
    sensor = 4'b0100;
    do_reset();
    step(2);  expect_pd("hold_g2", 1, 2);
    chk("hold_g2_triple", int'(lights[8:6]), 3'b001);
    step(100); expect_pd("hold_g2_late", 1, 2);
    chk("hold_g2_lights", int'(lights), 12'h864);

    // Others rise at green cycle 5: yellow at 20, then dir3 wins over dir0.
    do_reset();
    step(2);  expect_pd("rr_g2", 1, 2);
    step(4);  sensor = 4'b1101;
    step(15); expect_pd("rr_g2_last", 1, 2);
    step(1);  expect_pd("rr_y2", 2, 2);
    step(4);  expect_pd("rr_ar", 0, 2);
    step(2);  expect_pd("rr_g3", 1, 3);

    // Reset mid-yellow on dir1.
    sensor = 4'b0000;
    do_reset();
    step(48); expect_pd("mid_y1", 2, 1);
    rst = 1'b1;
    step(1);
    chk("mid_rst_lights", int'(lights), 12'h924);
    expect_pd("mid_rst", 0, 3);
    rst = 1'b0;
    step(1);  expect_pd("mid_rst_ar2", 0, 3);
    step(1);  expect_pd("mid_rst_g0", 1, 0);

`ifdef TRAFFIC_PED_WALK_EN
    // Pedestrian request during dir0 green.
    do_reset();
    step(2);  expect_pd("ped_g0", 1, 0);
    ped_req = 1'b1; step(1); ped_req = 1'b0;
    step(18); expect_pd("ped_g0_last", 1, 0);
    step(1);  expect_pd("ped_y0", 2, 0);
    step(4);  expect_pd("ped_ar", 0, 0);
    step(2);  expect_pd("ped_walk", 3, 0);
    chk("ped_walk_hi", int'(walk), 1);
    step(9);  chk("ped_walk_last", int'(walk), 1);
    step(1);  expect_pd("ped_ar2", 0, 0);
    chk("ped_walk_lo", int'(walk), 0);
    step(2);  expect_pd("ped_g1", 1, 1);
`endif

    // Random demand soak; the compare process checks every cycle.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 7) == 0) sensor = 4'($urandom_range(0, 15));
`ifdef TRAFFIC_PED_WALK_EN
      ped_req = ($urandom_range(0, 63) == 0);
`endif
      step(1);
    end
    ped_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
